alu_serial: RTL and testbench



---
 rtl/alu_serial.sv | 261 ++++++++++++++++++++++++++
 tb/tb_alu_serial.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial.sv
// Serial 32-bit ALU responder: receives B/A/CTL frames on sin, answers with a result packet or error frame on sout.
// Optional feature macro ALU_SERIAL_STOP_CHECK_EN: a stop bit sampled as 0 flags the packet as ERR_DATA.
`timescale 1ns/1ps
module alu_serial (
  input  logic clk,
  input  logic rst_n,
  input  logic sin,
  output logic sout
);

  typedef enum logic [1:0] {RX_IDLE, RX_BITS, RX_DECODE} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_SHIFT} tx_state_e;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  rx_state_e   rx_state_q, rx_state_d;
  logic [3:0]  rx_cnt_q, rx_cnt_d;
  logic [8:0]  rx_sr_q, rx_sr_d;
  logic [63:0] data_q, data_d;
  logic [3:0]  dcnt_q, dcnt_d;
  logic [6:0]  ctl_q, ctl_d;
  logic        stop_err_q, stop_err_d;
  logic        stop_bad;

  tx_state_e   tx_state_q, tx_state_d;
  logic [54:0] tx_vec_q, tx_vec_d;
  logic [5:0]  tx_cnt_q, tx_cnt_d;
  logic        tx_long_q, tx_long_d;
  logic        sout_q, sout_d;
  logic [54:0] pend_vec_q, pend_vec_d;
  logic        pend_long_q, pend_long_d;
  logic        pend_valid_q, pend_valid_d;

  logic        dec_valid, dec_taken;
  logic [31:0] op_b, op_a, res_c;
  logic [32:0] sum, diff;
  logic [2:0]  op;
  logic        carry, ovf, op_bad;
  logic [3:0]  flags;
  logic        err_data, err_crc, err_op;
  logic [2:0]  err3;
  logic        resp_long;
  logic [54:0] resp_vec;

`ifdef ALU_SERIAL_STOP_CHECK_EN
  assign stop_bad = ~sin;
`else
  assign stop_bad = 1'b0;
`endif

  function automatic logic [10:0] mk_frame(input logic t, input logic [7:0] p);
    return {1'b0, t, p, 1'b1};
  endfunction

  function automatic logic [3:0] crc4_calc(input logic [67:0] msg);
    logic [3:0] r;
    logic       fb;
    r = 4'b0000;
    for (int i = 67; i >= 0; i--) begin
      fb = r[3] ^ msg[i];
      r  = {r[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return r;
  endfunction

  function automatic logic [2:0] crc3_calc(input logic [36:0] msg);
    logic [2:0] r;
    logic       fb;
    r = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      fb = r[2] ^ msg[i];
      r  = {r[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
    end
    return r;
  endfunction

  // DECODE doubles as idle so a start bit right after a CTL stop bit is not missed.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_sr_d    = rx_sr_q;
    data_d     = data_q;
    dcnt_d     = dcnt_q;
    ctl_d      = ctl_q;
    stop_err_d = stop_err_q;
    case (rx_state_q)
      RX_IDLE, RX_DECODE: begin
        if (rx_state_q == RX_DECODE) begin
          dcnt_d     = 4'd0;
          stop_err_d = 1'b0;
        end
        if (!sin) begin
          rx_state_d = RX_BITS;
          rx_cnt_d   = 4'd10;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_BITS: begin
        rx_cnt_d = rx_cnt_q - 4'd1;
        rx_sr_d  = {rx_sr_q[7:0], sin};
        if (rx_cnt_q == 4'd1) begin
          stop_err_d = stop_err_q | stop_bad;
          if (rx_sr_q[8]) begin
            ctl_d      = rx_sr_q[6:0];
            rx_state_d = RX_DECODE;
          end else begin
            data_d     = {data_q[55:0], rx_sr_q[7:0]};
            if (dcnt_q != 4'd9) dcnt_d = dcnt_q + 4'd1;
            rx_state_d = RX_IDLE;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign dec_valid = (rx_state_q == RX_DECODE);

  always_comb begin
    op_b   = data_q[63:32];
    op_a   = data_q[31:0];
    op     = ctl_q[6:4];
    sum    = {1'b0, op_b} + {1'b0, op_a};
    diff   = {1'b0, op_b} - {1'b0, op_a};
    res_c  = 32'd0;
    carry  = 1'b0;
    ovf    = 1'b0;
    op_bad = 1'b0;
    case (op)
      OP_AND: res_c = op_b & op_a;
      OP_OR:  res_c = op_b | op_a;
      OP_ADD: begin
        res_c = sum[31:0];
        carry = sum[32];
        ovf   = (op_b[31] == op_a[31]) && (sum[31] != op_b[31]);
      end
      OP_SUB: begin
        res_c = diff[31:0];
        carry = diff[32];
        ovf   = (op_b[31] != op_a[31]) && (diff[31] != op_b[31]);
      end
      default: op_bad = 1'b1;
    endcase
    flags     = {carry, ovf, (res_c == 32'd0), res_c[31]};
    err_data  = (dcnt_q != 4'd8) || stop_err_q;
    err_crc   = !err_data && (crc4_calc({op_b, op_a, 1'b1, op}) != ctl_q[3:0]);
    err_op    = !err_data && !err_crc && op_bad;
    err3      = {err_data, err_crc, err_op};
    resp_long = (err3 == 3'b000);
    if (resp_long)
      resp_vec = {mk_frame(1'b0, res_c[31:24]), mk_frame(1'b0, res_c[23:16]),
                  mk_frame(1'b0, res_c[15:8]),  mk_frame(1'b0, res_c[7:0]),
                  mk_frame(1'b1, {1'b0, flags, crc3_calc({res_c, 1'b0, flags})})};
    else
      resp_vec = {mk_frame(1'b1, {1'b1, err3, err3, ^{1'b1, err3, err3}}), {44{1'b1}}};
  end

  // At the last bit of a response the next one (pending first, then fresh decode) follows with no gap.
  always_comb begin
    tx_state_d   = tx_state_q;
    tx_vec_d     = tx_vec_q;
    tx_cnt_d     = tx_cnt_q;
    tx_long_d    = tx_long_q;
    sout_d       = sout_q;
    pend_vec_d   = pend_vec_q;
    pend_long_d  = pend_long_q;
    pend_valid_d = pend_valid_q;
    dec_taken    = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        sout_d = 1'b1;
        if (pend_valid_q) begin
          tx_vec_d     = pend_vec_q;
          tx_long_d    = pend_long_q;
          pend_valid_d = 1'b0;
          tx_state_d   = TX_LOAD;
        end else if (dec_valid) begin
          tx_vec_d   = resp_vec;
          tx_long_d  = resp_long;
          dec_taken  = 1'b1;
          tx_state_d = TX_LOAD;
        end
      end
      TX_LOAD: begin
        sout_d     = tx_vec_q[54];
        tx_vec_d   = {tx_vec_q[53:0], 1'b1};
        tx_cnt_d   = tx_long_q ? 6'd54 : 6'd10;
        tx_state_d = TX_SHIFT;
      end
      TX_SHIFT: begin
        if (tx_cnt_q != 6'd0) begin
          sout_d   = tx_vec_q[54];
          tx_vec_d = {tx_vec_q[53:0], 1'b1};
          tx_cnt_d = tx_cnt_q - 6'd1;
        end else if (pend_valid_q) begin
          sout_d       = pend_vec_q[54];
          tx_vec_d     = {pend_vec_q[53:0], 1'b1};
          tx_cnt_d     = pend_long_q ? 6'd54 : 6'd10;
          pend_valid_d = 1'b0;
        end else if (dec_valid) begin
          sout_d    = resp_vec[54];
          tx_vec_d  = {resp_vec[53:0], 1'b1};
          tx_cnt_d  = resp_long ? 6'd54 : 6'd10;
          dec_taken = 1'b1;
        end else begin
          sout_d     = 1'b1;
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (dec_valid && !dec_taken && !pend_valid_q) begin
      pend_valid_d = 1'b1;
      pend_vec_d   = resp_vec;
      pend_long_d  = resp_long;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= 4'd0;
      rx_sr_q      <= '0;
      data_q       <= '0;
      dcnt_q       <= 4'd0;
      ctl_q        <= '0;
      stop_err_q   <= 1'b0;
      tx_state_q   <= TX_IDLE;
      tx_vec_q     <= '1;
      tx_cnt_q     <= 6'd0;
      tx_long_q    <= 1'b0;
      sout_q       <= 1'b1;
      pend_vec_q   <= '1;
      pend_long_q  <= 1'b0;
      pend_valid_q <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_sr_q      <= rx_sr_d;
      data_q       <= data_d;
      dcnt_q       <= dcnt_d;
      ctl_q        <= ctl_d;
      stop_err_q   <= stop_err_d;
      tx_state_q   <= tx_state_d;
      tx_vec_q     <= tx_vec_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_long_q    <= tx_long_d;
      sout_q       <= sout_d;
      pend_vec_q   <= pend_vec_d;
      pend_long_q  <= pend_long_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign sout = sout_q;

endmodule

// File: tb/tb_alu_serial.sv
// Scoreboard bench for alu_serial: stimulus queues expected sout frames (with start cycles), a monitor checks them.
`timescale 1ns/1ps
module tb_alu_serial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sin = 1'b1;
  logic sout;

  alu_serial dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sin   (sin),
    .sout  (sout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  logic [10:0] exp_frame_q[$];
  int          exp_cyc_q[$];
  string       exp_name_q[$];

  function automatic logic [10:0] mk_frame(input logic t, input logic [7:0] p);
    return {1'b0, t, p, 1'b1};
  endfunction

  // CRCs as polynomial long division of msg * x^n.
  function automatic logic [3:0] crc4_model(input logic [67:0] m);
    logic [71:0] r;
    r = {m, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  function automatic logic [2:0] crc3_model(input logic [36:0] m);
    logic [39:0] r;
    r = {m, 3'b000};
    for (int i = 39; i >= 3; i--)
      if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
    return r[2:0];
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk);
    sin = b;
  endtask

  task automatic send_frame(input logic t, input logic [7:0] p);
    logic [10:0] f;
    f = mk_frame(t, p);
    for (int i = 10; i >= 0; i--) send_bit(f[i]);
  endtask

  task automatic send_cmd(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                          input logic [3:0] crc_adj, input int ndata);
    logic [63:0] ba;
    logic [3:0]  crc;
    ba  = {b, a};
    crc = crc4_model({b, a, 1'b1, op}) + crc_adj;
    for (int i = 0; i < ndata; i++) send_frame(1'b0, ba[63-8*i -: 8]);
    send_frame(1'b1, {1'b0, op, crc});
  endtask

  task automatic expect_frame(input logic [10:0] f, input int c, input string n);
    exp_frame_q.push_back(f);
    exp_cyc_q.push_back(c);
    exp_name_q.push_back(n);
  endtask

  task automatic expect_ok(input string n, input logic [31:0] c, input logic [3:0] fl, input int start);
    for (int i = 0; i < 4; i++)
      expect_frame(mk_frame(1'b0, c[31-8*i -: 8]), start + 11*i, $sformatf("%s_d%0d", n, i));
    expect_frame(mk_frame(1'b1, {1'b0, fl, crc3_model({c, 1'b0, fl})}), start + 44, {n, "_ctl"});
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_frame_q.size() != 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    while (exp_frame_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: no frame seen, expected %b at cycle %0d",
               exp_name_q[0], exp_frame_q[0], exp_cyc_q[0]);
      void'(exp_frame_q.pop_front());
      void'(exp_cyc_q.pop_front());
      void'(exp_name_q.pop_front());
    end
    repeat (5) @(negedge clk);
  endtask

  // Monitor: captures each 11-bit frame on sout and checks it against the queue head.
  initial begin
    logic [10:0] fr;
    logic [10:0] ef;
    int          st, ec;
    string       en;
    bit          ok;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && sout === 1'b0) begin
        st = cyc;
        fr = '0;
        ok = 1'b1;
        for (int i = 9; i >= 0; i--) begin
          @(negedge clk);
          fr[i] = sout;
          if (!rst_n || !mon_en) ok = 1'b0;
        end
        if (ok) begin
          n_cmp++;
          if (exp_frame_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_frame: got %b at cycle %0d, expected no frame", fr, st);
          end else begin
            ef = exp_frame_q.pop_front();
            ec = exp_cyc_q.pop_front();
            en = exp_name_q.pop_front();
            if (fr !== ef || st != ec) begin
              n_fail++;
              $display("FAIL %s: got %b at cycle %0d, expected %b at cycle %0d", en, fr, st, ef, ec);
            end else begin
              $display("ok   %s: frame %b at cycle %0d", en, fr, st);
            end
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  s1;
    int  bad;
    bit  found;

    rst_n = 1'b0;
    sin   = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sout !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: sout=%b, expected 1", sout);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Abort a response in flight with an asynchronous reset.
    send_cmd(32'd1, 32'd2, 3'b100, 4'd0, 8);
    found = 1'b0;
    for (int w = 0; w < 20 && !found; w++) begin
      @(negedge clk);
      if (sout === 1'b0) found = 1'b1;
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (!found || sout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_precond: response start found=%0d sout=%b, expected found=1 sout=0", found, sout);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (sout !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_async: sout=%b right after rst_n fell, expected 1", sout);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int w = 0; w < 80; w++) begin
      @(negedge clk);
      if (sout !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL post_reset_idle: %0d low cycles on sout, expected 0", bad);
    end else begin
      $display("ok   post_reset_idle: sout held high");
    end
    mon_en = 1'b1;

    send_cmd(32'h0000_0001, 32'h0000_0002, 3'b100, 4'd0, 8);
    expect_ok("add_small", 32'h0000_0003, 4'b0000, cyc + 3);
    drain();

    send_cmd(32'hFF00_FF00, 32'hF0F0_F0F0, 3'b000, 4'd0, 8);
    expect_ok("and", 32'hF000_F000, 4'b0001, cyc + 3);
    drain();

    send_cmd(32'h1234_0000, 32'h0000_5678, 3'b001, 4'd0, 8);
    expect_ok("or", 32'h1234_5678, 4'b0000, cyc + 3);
    drain();

    send_cmd(32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 4'd0, 8);
    expect_ok("add_wrap", 32'h0000_0000, 4'b1010, cyc + 3);
    drain();

    send_cmd(32'h8000_0000, 32'h0000_0001, 3'b101, 4'd0, 8);
    expect_ok("sub_ovf", 32'h7FFF_FFFF, 4'b0100, cyc + 3);
    drain();

    send_cmd(32'h0000_0005, 32'h0000_0003, 3'b101, 4'd0, 7);
    expect_frame(mk_frame(1'b1, {1'b1, 6'b100100, 1'b1}), cyc + 3, "err_data");
    drain();

    send_cmd(32'h0000_0005, 32'h0000_0003, 3'b100, 4'd1, 8);
    expect_frame(mk_frame(1'b1, {1'b1, 6'b010010, 1'b1}), cyc + 3, "err_crc");
    drain();

    send_cmd(32'h0000_0005, 32'h0000_0003, 3'b111, 4'd0, 8);
    expect_frame(mk_frame(1'b1, {1'b1, 6'b001001, 1'b1}), cyc + 3, "err_op");
    drain();

    // Two short CTL-only packets land while the first response shifts: one waits, one is dropped.
    send_cmd(32'h8000_0000, 32'h0000_0001, 3'b101, 4'd0, 8);
    s1 = cyc + 3;
    expect_ok("b2b_first", 32'h7FFF_FFFF, 4'b0100, s1);
    expect_frame(mk_frame(1'b1, {1'b1, 6'b100100, 1'b1}), s1 + 55, "b2b_pending");
    send_frame(1'b1, 8'h00);
    send_frame(1'b1, 8'h00);
    drain();
    repeat (80) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
